// File: rtl/trail_pkg.sv
// Shared trail-pixel types: blend modes, packed {y, cb, cr} pixel, widths.
// Used by the blend pipeline and the frame-buffer side.
package trail_pkg;

  localparam int Y_W   = 4;
  localparam int CB_W  = 2;
  localparam int CR_W  = 2;
  localparam int PIX_W = Y_W + CB_W + CR_W;

  typedef enum logic [1:0] {
    PASS   = 2'd0,
    THRESH = 2'd1,
    MAX    = 2'd2
  } trail_mode_t;

  typedef struct packed {
    logic [Y_W-1:0]  y;
    logic [CB_W-1:0] cb;
    logic [CR_W-1:0] cr;
  } pixel_t;

endpackage

// File: rtl/trail_luma_decay.sv
// Combinational luma decay: dec_y = y - max(y >> shift, 1); shift 0 freezes.
// Ports: y_in, shift_in -> dec_y_out.
module trail_luma_decay #(
  parameter int Y_BITS  = 4,
  parameter int SH_BITS = $clog2(Y_BITS + 1)
) (
  input  logic [Y_BITS-1:0]  y_in,
  input  logic [SH_BITS-1:0] shift_in,
  output logic [Y_BITS-1:0]  dec_y_out
);

  logic [Y_BITS-1:0] d;

  always_comb begin
    d = y_in >> shift_in;
    if (shift_in == '0) begin
      d = '0;
    end else if (y_in != '0 && d == '0) begin
      // minimum step of 1 so trails always reach zero
      d = Y_BITS'(1);
    end
    dec_y_out = y_in - d;
  end

endmodule

// File: rtl/trail_blend_pipe.sv
// Two-stage trail blend: camera + history pixel -> new history pixel.
// Ports: valid/ready in+out, frame_start, pixels, frame-latched mode/decay/threshold.
module trail_blend_pipe
  import trail_pkg::*;
#(
  parameter int          Y_BITS        = Y_W,
  parameter int          CB_BITS       = CB_W,
  parameter int          CR_BITS       = CR_W,
  parameter int          COLOR_DEPTH   = PIX_W,
  parameter int          THRESHOLD     = 11,
  parameter int          DECAY_DEFAULT = 2,
  parameter trail_mode_t MODE_DEFAULT  = THRESH,
  parameter int          FLOOR_Y       = 1
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         valid_in,
  output logic                         ready_out,
  input  logic                         frame_start_in,
  input  logic [COLOR_DEPTH-1:0]       history_in,
  input  logic [COLOR_DEPTH-1:0]       camera_in,
  input  logic [1:0]                   mode_in,
  input  logic [$clog2(Y_BITS+1)-1:0]  decay_shift_in,
  input  logic [Y_BITS-1:0]            threshold_in,
  output logic                         valid_out,
  input  logic                         ready_in,
  output logic                         frame_start_out,
  output logic [COLOR_DEPTH-1:0]       update_out
);

  localparam int SH_BITS = $clog2(Y_BITS + 1);
  localparam int C_BITS  = CB_BITS + CR_BITS;
  localparam logic [SH_BITS-1:0] DECAY_RST = SH_BITS'(DECAY_DEFAULT);
  localparam logic [Y_BITS-1:0]  THR_RST   = Y_BITS'(THRESHOLD);
  localparam logic [Y_BITS-1:0]  FLOOR_V   = Y_BITS'(FLOOR_Y);

  if (COLOR_DEPTH != Y_BITS + CB_BITS + CR_BITS) begin : g_bad_width
    $error("COLOR_DEPTH must equal Y_BITS+CB_BITS+CR_BITS");
  end

  typedef struct packed {
    logic               valid;
    logic               fs;
    logic [1:0]         mode;
    logic [COLOR_DEPTH-1:0] cam;
    logic [C_BITS-1:0]  hist_c;
    logic [Y_BITS-1:0]  dec_y;
    logic               ge_thr;
    logic               ge_dec;
  } s1_t;

  typedef struct packed {
    logic                   valid;
    logic                   fs;
    logic [COLOR_DEPTH-1:0] pix;
  } s2_t;

  logic [1:0]         mode_q, mode_d;
  logic [SH_BITS-1:0] shift_q, shift_d;
  logic [Y_BITS-1:0]  thr_q, thr_d;
  s1_t                s1_q, s1_d;
  s2_t                s2_q, s2_d;

  logic               en;
  logic               cfg_load;
  logic [Y_BITS-1:0]  hist_y;
  logic [Y_BITS-1:0]  cam_y;
  logic [Y_BITS-1:0]  dec_y;
  logic [COLOR_DEPTH-1:0] sel;
  logic [Y_BITS-1:0]  sel_y;
  logic               use_floor;

  assign en        = !s2_q.valid || ready_in;
  assign ready_out = en;
  assign cfg_load  = valid_in && en && frame_start_in;

  assign valid_out       = s2_q.valid;
  assign frame_start_out = s2_q.fs;
  assign update_out      = s2_q.pix;

  assign hist_y = history_in[COLOR_DEPTH-1 -: Y_BITS];
  assign cam_y  = camera_in[COLOR_DEPTH-1 -: Y_BITS];

  // _d doubles as the effective config: frame-start beats bypass the regs
  always_comb begin
    mode_d  = mode_q;
    shift_d = shift_q;
    thr_d   = thr_q;
    if (cfg_load) begin
      mode_d  = mode_in;
      shift_d = decay_shift_in;
      thr_d   = threshold_in;
    end
  end

  trail_luma_decay #(
    .Y_BITS  (Y_BITS),
    .SH_BITS (SH_BITS)
  ) u_decay (
    .y_in      (hist_y),
    .shift_in  (shift_d),
    .dec_y_out (dec_y)
  );

  always_comb begin
    s1_d = s1_q;
    if (en) begin
      s1_d.valid  = valid_in;
      s1_d.fs     = valid_in && frame_start_in;
      s1_d.mode   = mode_d;
      s1_d.cam    = camera_in;
      s1_d.hist_c = history_in[C_BITS-1:0];
      s1_d.dec_y  = dec_y;
      s1_d.ge_thr = cam_y >= thr_d;
      s1_d.ge_dec = cam_y >= dec_y;
    end
  end

  always_comb begin
    sel       = s1_q.cam;
    use_floor = 1'b0;
    unique case (1'b1)
      (s1_q.mode == THRESH): begin
        use_floor = 1'b1;
        if (!s1_q.ge_thr) sel = {s1_q.dec_y, s1_q.hist_c};
      end
      (s1_q.mode == MAX): begin
        use_floor = 1'b1;
        if (!s1_q.ge_dec) sel = {s1_q.dec_y, s1_q.hist_c};
      end
      default: ;
    endcase
    sel_y = sel[COLOR_DEPTH-1 -: Y_BITS];
    if (use_floor && sel_y < FLOOR_V) sel = '0;
    s2_d = s2_q;
    if (en) begin
      s2_d.valid = s1_q.valid;
      s2_d.fs    = s1_q.fs;
      s2_d.pix   = sel;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mode_q  <= MODE_DEFAULT;
      shift_q <= DECAY_RST;
      thr_q   <= THR_RST;
      s1_q    <= '0;
      s2_q    <= '0;
    end else begin
      mode_q  <= mode_d;
      shift_q <= shift_d;
      thr_q   <= thr_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
    end
  end

endmodule
